// File: rtl/reg_temp_prom_pkg.sv
// Shared constants for the temperature sample register: default geometry and code limits.
package reg_temp_prom_pkg;

  localparam int unsigned W_DEF     = 3;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned LOG2D_DEF = 2;

  // Temperature code range for the default width.
  localparam logic [W_DEF-1:0] TEMP_CODE_MIN = '0;
  localparam logic [W_DEF-1:0] TEMP_CODE_MAX = '1;

endpackage

// File: rtl/buf_circ_temp.sv
// DEPTH x W circular sample history: owns the write pointer, fill count and the full flag.
module buf_circ_temp
  import reg_temp_prom_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LOG2D = LOG2D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] old_data_c,
  output logic         empty_c,
  output logic         full_next_c,
  output logic         lleno
);

  localparam int unsigned CW = LOG2D + 1;

  logic [W-1:0]       hist [DEPTH];
  logic [LOG2D-1:0]   wr_ptr;
  logic [CW-1:0]      count;
  logic               wr_ok_c;

  // Slot about to be overwritten; read before the write lands.
  assign old_data_c  = hist[wr_ptr];
  assign empty_c     = (count == '0);
  assign full_next_c = ((count + CW'(1)) >= CW'(DEPTH));
  assign wr_ok_c     = wr & ~reset & ~clr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      count  <= '0;
      lleno  <= 1'b0;
    end else if (wr) begin
      wr_ptr <= wr_ptr + LOG2D'(1);
      if (!lleno) count <= count + CW'(1);
      lleno  <= full_next_c;
    end
  end

  // Storage is never read before written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok_c) hist[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/reg_temp_prom.sv
// Latest-sample register with windowed moving average and running max/min since clear.
module reg_temp_prom
  import reg_temp_prom_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LOG2D = LOG2D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         leer,
  input  logic [W-1:0] dato,
  input  logic         clear_hist,
  output logic [W-1:0] temp,
  output logic [W-1:0] temp_prom,
  output logic [W-1:0] temp_max,
  output logic [W-1:0] temp_min,
  output logic         lleno,
  output logic         prom_valido
);

  localparam int unsigned SW = W + LOG2D;

  logic [W-1:0]  old_data_c;
  logic          empty_c;
  logic          full_next_c;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next_c;
  logic [SW-1:0] sum_avg_c;

  buf_circ_temp #(
    .W     (W),
    .DEPTH (DEPTH),
    .LOG2D (LOG2D)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .clr         (clear_hist),
    .wr          (leer),
    .wr_data     (dato),
    .old_data_c  (old_data_c),
    .empty_c     (empty_c),
    .full_next_c (full_next_c),
    .lleno       (lleno)
  );

  // Window sum: add the new sample, retire the evicted one once the window is full.
  always_comb begin
    sum_next_c = sum + SW'(dato);
    if (lleno) sum_next_c = sum_next_c - SW'(old_data_c);
    sum_avg_c  = sum_next_c >> LOG2D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp        <= '0;
      temp_prom   <= '0;
      temp_max    <= '0;
      temp_min    <= '1;
      prom_valido <= 1'b0;
      sum         <= '0;
    end else if (clear_hist) begin
      temp_prom   <= '0;
      temp_max    <= '0;
      temp_min    <= '1;
      prom_valido <= 1'b0;
      sum         <= '0;
    end else if (leer) begin
      temp        <= dato;
      sum         <= sum_next_c;
      temp_prom   <= full_next_c ? W'(sum_avg_c) : '0;
      prom_valido <= full_next_c;
      // First sample after reset/clear seeds both extremes.
      if (empty_c) begin
        temp_max <= dato;
        temp_min <= dato;
      end else begin
        if (dato > temp_max) temp_max <= dato;
        if (dato < temp_min) temp_min <= dato;
      end
    end
  end

endmodule

// File: tb/tb_reg_temp_prom.sv
// Scoreboard bench for reg_temp_prom: directed vectors push expectations, a monitor pops and compares.
module tb_reg_temp_prom;
  import reg_temp_prom_pkg::*;

  localparam int unsigned W     = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LOG2D = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         leer = 1'b0;
  logic [W-1:0] dato = '0;
  logic         clear_hist = 1'b0;
  logic [W-1:0] temp, temp_prom, temp_max, temp_min;
  logic         lleno, prom_valido;

  typedef struct packed {
    logic [W-1:0] temp;
    logic [W-1:0] prom;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    logic         lleno;
    logic         valido;
  } exp_t;

  exp_t expq[$];
  exp_t e_cur;
  int   checks = 0;
  int   failures = 0;
  int   vec = 0;
  logic chk_req = 1'b0;
  logic chk_pend = 1'b0;

  always #5 clk = ~clk;

  reg_temp_prom #(.W(W), .DEPTH(DEPTH), .LOG2D(LOG2D)) dut (
    .clk         (clk),
    .reset       (reset),
    .leer        (leer),
    .dato        (dato),
    .clear_hist  (clear_hist),
    .temp        (temp),
    .temp_prom   (temp_prom),
    .temp_max    (temp_max),
    .temp_min    (temp_min),
    .lleno       (lleno),
    .prom_valido (prom_valido)
  );

  function automatic exp_t mk(input int t, input int p, input int mx, input int mn,
                              input int ll, input int v);
    exp_t r;
    r.temp   = W'(t);
    r.prom   = W'(p);
    r.mx     = W'(mx);
    r.mn     = W'(mn);
    r.lleno  = ll[0];
    r.valido = v[0];
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", nm, idx, act, want);
    end
  endtask

  // Flag the cycle whose edge produced a result the scoreboard is waiting for.
  always @(posedge clk) chk_pend <= chk_req;

  always @(negedge clk) begin
    if (chk_pend) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow vec=%0d", vec);
      end else begin
        e_cur = expq.pop_front();
        chk("temp",        vec, int'(temp),        int'(e_cur.temp));
        chk("temp_prom",   vec, int'(temp_prom),   int'(e_cur.prom));
        chk("temp_max",    vec, int'(temp_max),    int'(e_cur.mx));
        chk("temp_min",    vec, int'(temp_min),    int'(e_cur.mn));
        chk("lleno",       vec, int'(lleno),       int'(e_cur.lleno));
        chk("prom_valido", vec, int'(prom_valido), int'(e_cur.valido));
        vec++;
      end
    end
  end

  task automatic step(input logic r, input logic c, input logic l, input int d, input exp_t e);
    reset      = r;
    clear_hist = c;
    leer       = l;
    dato       = W'(d);
    expq.push_back(e);
    chk_req    = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    clear_hist = 1'b0;
    leer       = 1'b0;
    chk_req    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout vec=%0d", vec);
    $fatal(1);
  end

  initial begin
    if ((1 << LOG2D) != DEPTH) begin
      $display("FAIL param_log2d LOG2D=%0d DEPTH=%0d", LOG2D, DEPTH);
      $fatal(1);
    end
    @(posedge clk);
    #1;

    // Reset state
    step(1, 0, 0, 0, mk(0, 0, 0, 7, 0, 0));
    // First sample seeds max and min
    step(0, 0, 1, 5, mk(5, 0, 5, 5, 0, 0));
    step(1, 0, 0, 0, mk(0, 0, 0, 7, 0, 0));
    // Fill window 1,2,3,4 -> avg 10>>2
    step(0, 0, 1, 1, mk(1, 0, 1, 1, 0, 0));
    step(0, 0, 1, 2, mk(2, 0, 2, 1, 0, 0));
    step(0, 0, 1, 3, mk(3, 0, 3, 1, 0, 0));
    step(0, 0, 1, 4, mk(4, 2, 4, 1, 1, 1));
    // Sliding window with wrap: 16,21,25,28 sums
    step(0, 0, 1, 7, mk(7, 4, 7, 1, 1, 1));
    step(0, 0, 1, 7, mk(7, 5, 7, 1, 1, 1));
    step(0, 0, 1, 7, mk(7, 6, 7, 1, 1, 1));
    step(0, 0, 1, 7, mk(7, 7, 7, 1, 1, 1));
    // Clear beats a simultaneous sample; temp holds
    step(0, 1, 1, 6, mk(7, 0, 0, 7, 0, 0));
    step(0, 0, 1, 6, mk(6, 0, 6, 6, 0, 0));
    step(0, 0, 1, 3, mk(3, 0, 6, 3, 0, 0));
    step(0, 0, 1, 2, mk(2, 0, 6, 2, 0, 0));
    // Reset beats a simultaneous sample, temp included
    step(1, 0, 1, 5, mk(0, 0, 0, 7, 0, 0));
    // Fill 1,2,3,6 -> 12>>2, then hold with junk on dato
    step(0, 0, 1, 1, mk(1, 0, 1, 1, 0, 0));
    step(0, 0, 1, 2, mk(2, 0, 2, 1, 0, 0));
    step(0, 0, 1, 3, mk(3, 0, 3, 1, 0, 0));
    step(0, 0, 1, 6, mk(6, 3, 6, 1, 1, 1));
    for (int i = 0; i < 20; i++) step(0, 0, 0, i % 8, mk(6, 3, 6, 1, 1, 1));
    // Pointer must not have moved: evicts 1 -> 2,3,6,7 = 18>>2
    step(0, 0, 1, 7, mk(7, 4, 7, 1, 1, 1));
    step(0, 0, 1, 0, mk(0, 4, 7, 0, 1, 1));

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
